// File: rtl/multi_ball_pkg.sv
// Shared types and default geometry for the multi-ball engine.
package multi_ball_pkg;

  // Position width used inside the ball state record.
  localparam int POS_W     = 10;
  // Stored speed width: MSB is the sign (1 = negative), the rest is magnitude.
  localparam int SPD_MAX_W = 8;
  localparam int MAG_W     = SPD_MAX_W - 1;

  // Default playfield geometry.
  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_BORDER    = 8;
  localparam int DEF_BALL_SIDE = 8;

  // Centre and limit constants derived from the default geometry.
  localparam int DEF_CENTRE_X = DEF_H_RES / 2;
  localparam int DEF_CENTRE_Y = DEF_V_RES / 2;
  localparam int DEF_X_GOAL_HI = DEF_H_RES - DEF_BORDER;
  localparam int DEF_Y_BOUNCE_HI = DEF_V_RES - DEF_BORDER - DEF_BALL_SIDE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } engine_state_e;

  typedef struct packed {
    logic [POS_W-1:0]     x;
    logic [POS_W-1:0]     y;
    logic [SPD_MAX_W-1:0] vx;
    logic [SPD_MAX_W-1:0] vy;
    logic                 act;
  } ball_t;

  // Advance a coordinate by a sign-magnitude speed.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic [SPD_MAX_W-1:0] v);
    logic [POS_W-1:0] mag;
    mag = POS_W'(v[MAG_W-1:0]);
    return v[SPD_MAX_W-1] ? (pos - mag) : (pos + mag);
  endfunction

endpackage

// File: rtl/ball_unit.sv
// One ball: position, speed, pending paddle hits and goal detection.
// Optional feature macro: BALL_SPEEDUP_EN (each consumed hit speeds x up by 1).
module ball_unit
  import multi_ball_pkg::*;
#(
  parameter int IDX       = 0,
  parameter int N_BALLS   = 2,
  parameter int SPEED_W   = 4,
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int BORDER    = DEF_BORDER,
  parameter int BALL_SIDE = DEF_BALL_SIDE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       serve_i,
  input  logic       launch_i,
  input  logic       step_i,
  input  logic [7:0] rnd_i,
  input  logic       p_hit_i,
  input  logic       e_hit_i,
  output ball_t      ball_o,
  output logic       p_goal_o,
  output logic       e_goal_o
);

`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [POS_W-1:0] CX      = POS_W'(H_RES / 2);
  localparam logic [POS_W-1:0] CY      = POS_W'(V_RES / 2);
  localparam logic [POS_W-1:0] SERVE_Y = POS_W'((IDX + 1) * V_RES / (N_BALLS + 1));
  localparam logic [POS_W-1:0] X_LO    = POS_W'(BORDER);
  localparam logic [POS_W-1:0] X_HI    = POS_W'(H_RES - BORDER);
  localparam logic [POS_W-1:0] Y_LO    = POS_W'(BORDER);
  // y + BALL_SIDE > V_RES - BORDER rewritten so nothing can overflow
  localparam logic [POS_W-1:0] Y_HI    = POS_W'(V_RES - BORDER - BALL_SIDE);
  localparam logic [MAG_W-1:0] MAG_MAX = MAG_W'((1 << (SPEED_W - 1)) - 1);
  localparam logic [MAG_W-1:0] MAG_X0  = MAG_W'(2);
  localparam logic [MAG_W-1:0] MAG_Y0  = MAG_W'(1);
  localparam int               RX      = IDX % 8;
  localparam int               RY      = (IDX + 4) % 8;
  localparam logic             IDX_LSB = 1'(IDX % 2);

  ball_t ball_reg, ball_next, serve_ball;
  logic  p_pend_reg, e_pend_reg;
  logic  hit_p, hit_e, p_goal, e_goal;
  logic  unused_rnd;

  assign unused_rnd = ^rnd_i;

  // Serve placement and launch direction for this ball.
  always_comb begin
    serve_ball     = '0;
    serve_ball.x   = CX;
    serve_ball.y   = SERVE_Y;
    serve_ball.vx  = {rnd_i[RX] ^ IDX_LSB, MAG_X0};
    serve_ball.vy  = {rnd_i[RY], MAG_Y0};
    serve_ball.act = 1'b0;
  end

  // Per-frame update: goal check first, then hit/border steering, then move.
  always_comb begin
    hit_p     = p_pend_reg | p_hit_i;
    hit_e     = e_pend_reg | e_hit_i;
    p_goal    = ball_reg.act && (ball_reg.x < X_LO);
    e_goal    = ball_reg.act && (ball_reg.x > X_HI);
    ball_next = ball_reg;
    if (p_goal || e_goal) begin
      ball_next.x   = CX;
      ball_next.y   = CY;
      ball_next.act = 1'b0;
    end else begin
      // player hit wins over an enemy hit in the same frame
      if (hit_p) begin
        ball_next.vx[SPD_MAX_W-1] = 1'b1;
      end else if (hit_e) begin
        ball_next.vx[SPD_MAX_W-1] = 1'b0;
      end
      if (SPEEDUP && (hit_p || hit_e) && (ball_reg.vx[MAG_W-1:0] < MAG_MAX)) begin
        ball_next.vx[MAG_W-1:0] = ball_reg.vx[MAG_W-1:0] + MAG_W'(1);
      end
      if (ball_reg.y < Y_LO) begin
        ball_next.vy[SPD_MAX_W-1] = 1'b0;
      end else if (ball_reg.y > Y_HI) begin
        ball_next.vy[SPD_MAX_W-1] = 1'b1;
      end
      ball_next.x = step_pos(ball_reg.x, ball_next.vx);
      ball_next.y = step_pos(ball_reg.y, ball_next.vy);
    end
  end

  // Hit pulses are remembered until the next playing frame consumes them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_pend_reg <= 1'b0;
      e_pend_reg <= 1'b0;
    end else if (step_i) begin
      p_pend_reg <= 1'b0;
      e_pend_reg <= 1'b0;
    end else begin
      p_pend_reg <= p_pend_reg | p_hit_i;
      e_pend_reg <= e_pend_reg | e_hit_i;
    end
  end

  // Ball state: serve placement, launch, or one frame of motion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ball_reg.x   <= CX;
      ball_reg.y   <= CY;
      ball_reg.vx  <= '0;
      ball_reg.vy  <= '0;
      ball_reg.act <= 1'b0;
    end else if (serve_i) begin
      ball_reg <= serve_ball;
    end else if (launch_i) begin
      ball_reg.act <= 1'b1;
    end else if (step_i && ball_reg.act) begin
      ball_reg <= ball_next;
    end
  end

  assign ball_o   = ball_reg;
  assign p_goal_o = step_i & p_goal;
  assign e_goal_o = step_i & e_goal;

endmodule

// File: rtl/multi_ball_engine.sv
// Multi-ball pong engine: game FSM, serve timer, scoring and per-ball units.
// Optional feature macro: BALL_SPEEDUP_EN (handled inside ball_unit).
module multi_ball_engine
  import multi_ball_pkg::*;
#(
  parameter int N_BALLS      = 2,
  parameter int SPEED_W      = 4,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int BORDER       = DEF_BORDER,
  parameter int BALL_SIDE    = DEF_BALL_SIDE,
  parameter int X_W          = 10,
  parameter int Y_W          = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   new_frame_i,
  input  logic                   start_i,
  input  logic                   pause_i,
  input  logic [7:0]             rnd_i,
  input  logic [N_BALLS-1:0]     p_hit_i,
  input  logic [N_BALLS-1:0]     e_hit_i,
  output logic [N_BALLS*X_W-1:0] ball_x_o,
  output logic [N_BALLS*Y_W-1:0] ball_y_o,
  output logic [N_BALLS-1:0]     ball_act_o,
  output logic [SCORE_W-1:0]     p_score_o,
  output logic [SCORE_W-1:0]     e_score_o,
  output logic [2:0]             state_o,
  output logic [1:0]             winner_o
);

  localparam int                 CNT_W    = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  engine_state_e        state_reg;
  logic [CNT_W-1:0]     serve_cnt_reg;
  logic [SCORE_W-1:0]   p_score_reg, e_score_reg, p_score_next, e_score_next;
  logic [1:0]           winner_reg;
  logic [N_BALLS-1:0]   p_goal, e_goal, act_left, unused_speed;
  logic                 step, launch, serve_load, rally_end, win;
  int                   p_goals, e_goals, p_sum, e_sum;
  ball_t                ball [N_BALLS];

  assign step   = new_frame_i && (state_reg == ST_PLAY) && !pause_i;
  assign launch = new_frame_i && (state_reg == ST_SERVE) && (serve_cnt_reg == CNT_LAST);

  // Count this frame's goals, saturate scores and detect the end of a rally.
  always_comb begin
    p_goals = 0;
    e_goals = 0;
    for (int i = 0; i < N_BALLS; i++) begin
      p_goals += int'(p_goal[i]);
      e_goals += int'(e_goal[i]);
    end
    p_sum        = int'(p_score_reg) + p_goals;
    e_sum        = int'(e_score_reg) + e_goals;
    p_score_next = (p_sum >= WIN_SCORE) ? WIN : SCORE_W'(p_sum);
    e_score_next = (e_sum >= WIN_SCORE) ? WIN : SCORE_W'(e_sum);
    act_left     = ball_act_o & ~(p_goal | e_goal);
    rally_end    = step && (|ball_act_o) && (act_left == '0);
    win          = (p_score_next == WIN) || (e_score_next == WIN);
    serve_load   = (start_i && ((state_reg == ST_IDLE) || (state_reg == ST_OVER))) ||
                   (rally_end && !win);
  end

  // Game FSM with serve timer, scores and winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      serve_cnt_reg <= '0;
      p_score_reg   <= '0;
      e_score_reg   <= '0;
      winner_reg    <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg     <= ST_SERVE;
            serve_cnt_reg <= '0;
          end
        end
        ST_SERVE: begin
          if (launch) begin
            state_reg     <= ST_PLAY;
            serve_cnt_reg <= '0;
          end else if (new_frame_i) begin
            serve_cnt_reg <= serve_cnt_reg + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (pause_i) begin
            state_reg <= ST_PAUSE;
          end else if (step) begin
            p_score_reg <= p_score_next;
            e_score_reg <= e_score_next;
            if (rally_end) begin
              if (win) begin
                state_reg  <= ST_OVER;
                winner_reg <= (p_score_next == WIN) ? 2'b01 : 2'b10;
              end else begin
                state_reg     <= ST_SERVE;
                serve_cnt_reg <= '0;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!pause_i) begin
            state_reg <= ST_PLAY;
          end
        end
        ST_OVER: begin
          if (start_i) begin
            state_reg     <= ST_SERVE;
            serve_cnt_reg <= '0;
            p_score_reg   <= '0;
            e_score_reg   <= '0;
            winner_reg    <= 2'b00;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_ball
    ball_unit #(
      .IDX       (gi),
      .N_BALLS   (N_BALLS),
      .SPEED_W   (SPEED_W),
      .H_RES     (H_RES),
      .V_RES     (V_RES),
      .BORDER    (BORDER),
      .BALL_SIDE (BALL_SIDE)
    ) u_ball (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .serve_i  (serve_load),
      .launch_i (launch),
      .step_i   (step),
      .rnd_i    (rnd_i),
      .p_hit_i  (p_hit_i[gi]),
      .e_hit_i  (e_hit_i[gi]),
      .ball_o   (ball[gi]),
      .p_goal_o (p_goal[gi]),
      .e_goal_o (e_goal[gi])
    );
    assign ball_x_o[gi*X_W +: X_W] = X_W'(ball[gi].x);
    assign ball_y_o[gi*Y_W +: Y_W] = Y_W'(ball[gi].y);
    assign ball_act_o[gi]          = ball[gi].act;
    assign unused_speed[gi]        = ^{ball[gi].vx, ball[gi].vy};
  end

  assign p_score_o = p_score_reg;
  assign e_score_o = e_score_reg;
  assign state_o   = state_reg;
  assign winner_o  = winner_reg;

endmodule
